// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high abcdefg font, entry n at HEX_FONT[n].
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-value bus from the producer and display pin outputs of the scan controller.
interface seg_scan_ctrl_if;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_done;

  modport master (output en, load, value, dp, input an_n, seg_n, dp_n, frame_done);
  modport slave  (input en, load, value, dp, output an_n, seg_n, dp_n, frame_done);
endinterface

// File: rtl/seg_scan_ctrl_scan_timer.sv
// Slot counter: counts 0..REFRESH_DIV-1 while running, flags the last lit cycle and slot end.
module scan_timer #(
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES  = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic gap_start,
  output logic slot_end
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt;

  assign gap_start = (cnt == CW'(REFRESH_DIV - GAP_CYCLES - 1));
  assign slot_end  = (cnt == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode scan controller with frame-synchronous shadow register and inter-digit blanking.
// Optional LEADING_ZERO_BLANK_EN darkens leading zero digits 3..1.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES  = 1000
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  localparam int IW = $clog2(NUM_DIGITS);

  state_t            state, state_nx;
  logic [IW-1:0]     idx, idx_nx;
  logic              run, gap_start, slot_end, boundary, lit;
  logic [15:0]       pend_val, shad_val;
  logic [3:0]        pend_dp, shad_dp;
  logic [3:0]        nib;
  logic [3:0]        an_d, an_q;
  logic [6:0]        seg_d, seg_q;
  logic              dp_d, dp_q, fd_q;

  assign run = bus.en && (state != IDLE);

  scan_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .GAP_CYCLES  (GAP_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .gap_start (gap_start),
    .slot_end  (slot_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    boundary = 1'b0;
    if (!bus.en) begin
      state_nx = IDLE;
      idx_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = SHOW;
          idx_nx   = '0;
        end
        SHOW: if (gap_start) state_nx = GAP;
        GAP: if (slot_end) begin
          state_nx = SHOW;
          idx_nx   = idx + IW'(1);
          boundary = (idx == IW'(NUM_DIGITS - 1));
        end
        default: state_nx = IDLE;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A zero digit is dark only if every digit above it is dark too; a set dp breaks the run.
  logic [NUM_DIGITS-1:0] lz;
  always_comb begin
    lz = '0;
    lz[NUM_DIGITS-1] = (shad_val[15:12] == 4'h0) && !shad_dp[NUM_DIGITS-1];
    for (int i = NUM_DIGITS - 2; i >= 1; i--) begin
      lz[i] = lz[i+1] && (shad_val[i*4 +: 4] == 4'h0) && !shad_dp[i];
    end
  end
  assign lit = !lz[idx];
`else
  assign lit = 1'b1;
`endif

  assign nib = shad_val[{idx, 2'b00} +: 4];

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state == SHOW && lit) begin
      an_d[idx] = 1'b0;
      seg_d     = ~HEX_FONT[nib];
      dp_d      = ~shad_dp[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_val <= '0;
      pend_dp  <= '0;
      shad_val <= '0;
      shad_dp  <= '0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      fd_q     <= 1'b0;
    end else begin
      if (bus.load) begin
        pend_val <= bus.value;
        pend_dp  <= bus.dp;
      end
      // A load on the boundary cycle bypasses pending so the newest value is never lost.
      if (boundary) begin
        shad_val <= bus.load ? bus.value : pend_val;
        shad_dp  <= bus.load ? bus.dp    : pend_dp;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      fd_q  <= boundary;
    end
  end

  assign bus.an_n       = an_q;
  assign bus.seg_n      = seg_q;
  assign bus.dp_n       = dp_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with REFRESH_DIV=8, GAP_CYCLES=2 (32-cycle frames).
module tb_seg_scan_ctrl;

  localparam logic [6:0] FONT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .REFRESH_DIV (8),
    .GAP_CYCLES  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_fd(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) seen = 1'b1;
    end
    chk({tag, "_fd_wait"}, 32'(seen), 32'd1);
  endtask

  // Checks one full frame starting just after a frame_done sample; ends on the next frame_done.
  task automatic check_frame(input string tag, input logic [15:0] v, input logic [3:0] d,
                             input logic [3:0] shown, input int ld_at,
                             input logic [15:0] lv, input logic [3:0] ld);
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       edp;
    logic [3:0] n;
    for (int k = 1; k <= 32; k++) begin
      int slot;
      int pos;
      @(negedge clk);
      slot = (k - 1) / 8;
      pos  = (k - 1) % 8;
      ean  = 4'hF;
      eseg = 7'h7F;
      edp  = 1'b1;
      if (pos < 6 && shown[slot]) begin
        n         = v[slot*4 +: 4];
        ean[slot] = 1'b0;
        eseg      = ~FONT[n];
        edp       = ~d[slot];
      end
      chk($sformatf("%s_an_k%0d", tag, k), 32'(bus.an_n), 32'(ean));
      if (pos >= 6 || shown[slot]) begin
        chk($sformatf("%s_seg_k%0d", tag, k), 32'(bus.seg_n), 32'(eseg));
        chk($sformatf("%s_dp_k%0d", tag, k), 32'(bus.dp_n), 32'(edp));
      end
      chk($sformatf("%s_fd_k%0d", tag, k), 32'(bus.frame_done), 32'(k == 32));
      if (k == ld_at) begin
        bus.load  = 1'b1;
        bus.value = lv;
        bus.dp    = ld;
      end else begin
        bus.load = 1'b0;
      end
    end
  endtask

  initial begin
    logic       fd_seen;
    logic [3:0] lzb_mask;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.load  = 1'b0;
    bus.value = 16'h0;
    bus.dp    = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_an", 32'(bus.an_n), 32'hF);
    chk("rst_seg", 32'(bus.seg_n), 32'h7F);
    chk("rst_dp", 32'(bus.dp_n), 32'h1);
    chk("rst_fd", 32'(bus.frame_done), 32'h0);

    fd_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.frame_done !== 1'b0) fd_seen = 1'b1;
    end
    chk("idle_an", 32'(bus.an_n), 32'hF);
    chk("idle_seg", 32'(bus.seg_n), 32'h7F);
    chk("idle_dp", 32'(bus.dp_n), 32'h1);
    chk("idle_fd", 32'(fd_seen), 32'h0);

    // Enable together with the first load; the first frame still shows the cleared shadow.
    bus.en    = 1'b1;
    bus.load  = 1'b1;
    bus.value = 16'h1234;
    bus.dp    = 4'b0010;
    @(negedge clk);
    bus.load = 1'b0;
    chk("en_c1_an", 32'(bus.an_n), 32'hF);
    @(negedge clk);
    chk("en_c2_an", 32'(bus.an_n), 32'hE);
    chk("en_c2_seg", 32'(bus.seg_n), 32'h01);
    chk("en_c2_dp", 32'(bus.dp_n), 32'h1);

    wait_fd("f0");
    check_frame("f1234", 16'h1234, 4'b0010, 4'hF, 12, 16'hABCD, 4'b0000);
    check_frame("fabcd", 16'hABCD, 4'b0000, 4'hF, 31, 16'hFFFF, 4'b1111);
    check_frame("fffff", 16'hFFFF, 4'b1111, 4'hF, 0, 16'h0, 4'h0);

    // Reset during digit 2 SHOW must darken outputs without waiting for a clock edge.
    repeat (19) @(negedge clk);
    chk("pre_rst_an", 32'(bus.an_n), 32'hB);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_an", 32'(bus.an_n), 32'hF);
    chk("async_rst_seg", 32'(bus.seg_n), 32'h7F);
    chk("async_rst_dp", 32'(bus.dp_n), 32'h1);
    chk("async_rst_fd", 32'(bus.frame_done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    bus.load  = 1'b1;
    bus.value = 16'h0050;
    bus.dp    = 4'b0000;
    @(negedge clk);
    bus.load = 1'b0;
    chk("resume_c1_an", 32'(bus.an_n), 32'hF);
    @(negedge clk);
    chk("resume_c2_an", 32'(bus.an_n), 32'hE);
    chk("resume_c2_seg", 32'(bus.seg_n), 32'h01);

`ifdef LEADING_ZERO_BLANK_EN
    lzb_mask = 4'b0011;
`else
    lzb_mask = 4'b1111;
`endif
    wait_fd("f_rst");
    check_frame("f0050", 16'h0050, 4'b0000, lzb_mask, 0, 16'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for a 4-digit common-anode seven-segment display. It latches a 16-bit hex value plus decimal points into a frame-synchronous shadow register, steps through the digits at a programmable refresh rate, and drives the active-low anodes and segments. A blanking gap between digits suppresses ghosting. It sits between the register/switch logic that produces display values and the board display pins.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz). Must be greater than `GAP_CYCLES`.
- `GAP_CYCLES`, default 1000: cycles at the end of each slot with all anodes off. Must be 1 or more.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: scan enable. When low, the display is dark.
- `value` input 16: four hex digits. Digit 0 is `value[3:0]` (rightmost).
- `dp` input 4: decimal point per digit, active-high.
- `load` input 1: one-cycle strobe that captures `value` and `dp` into pending.
- `an_n` output 4: anode selects, active-low, at most one low at a time.
- `seg_n` output 7: segments {a,b,c,d,e,f,g} with a as MSB, active-low.
- `dp_n` output 1: decimal point, active-low.
- `frame_done` output 1: one-cycle pulse at each frame boundary.

## Operation
- Reset values:
  - `an_n`=4'hF, `seg_n`=7'h7F, `dp_n`=1, `frame_done`=0.
  - digit index 0, slot counter 0, pending=0, shadow=0, state IDLE.
- FSM states: IDLE, SHOW, GAP.
  - IDLE → SHOW(digit 0, counter 0) on the first cycle `en`=1.
  - SHOW → GAP when the counter reaches `REFRESH_DIV-GAP_CYCLES-1`.
  - GAP → SHOW(next digit) when the counter reaches `REFRESH_DIV-1`.
  - After digit 3, the digit index wraps to 0.
  - Any state → IDLE on the cycle after `en`=0. IDLE restarts the sequence at digit 0.
- SHOW outputs:
  - `an_n` has only bit[index] low.
  - `seg_n` is the inverted hex font for the shadow nibble.
  - `dp_n` = ~shadow dp[index].
- GAP and IDLE outputs: `an_n`=4'hF, `seg_n`=7'h7F, `dp_n`=1.
- Hex font, active-high abcdefg:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
- Load and shadow rules:
  - `load`=1 overwrites pending with the current `value` and `dp`. The last load wins.
  - At the frame boundary (GAP→SHOW transition out of digit 3), shadow takes pending and `frame_done` pulses.
  - If `load` coincides with the boundary cycle, shadow takes the live `value`/`dp` directly.
  - A mid-frame `load` never changes the digits of the current frame (no tearing).
- Reset asserted mid-frame clears everything to reset values immediately. No partial digit survives.

## Timing
- All outputs are registered, one cycle after the state/counter change.
- A digit is lit for `REFRESH_DIV-GAP_CYCLES` cycles and dark for `GAP_CYCLES`. Frame length is 4×`REFRESH_DIV` cycles.
- Load-to-display latency: up to one frame plus one cycle. The new value appears in the first SHOW of digit 0 after the boundary.
- First lit digit after `en` rises: `an_n`=4'hE two cycles after `en`=1 is sampled.
- `frame_done` is high exactly one cycle per frame, and never in IDLE.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - Digits 3..1 whose nibble is 0 and whose higher digits are all 0 are blanked: `an_n` stays 4'hF during their SHOW.
  - Digit 0 is always shown.
  - Decimal points are unaffected; a digit with its dp set is never blanked.
- `LEADING_ZERO_BLANK_EN` undefined: all four digits are always shown.

## Structure
- Shared package `seg_pkg`:
  - 16-entry hex font constant (active-high abcdefg).
  - FSM state typedef.
  - `NUM_DIGITS`=4.
  - Inactive constants `AN_OFF`=4'hF and `SEG_OFF`=7'h7F.
- Sub-module `scan_timer`: slot counter with terminal-count and gap-start flags, parameterised by `REFRESH_DIV`/`GAP_CYCLES`. The FSM, shadow and output registers stay in the top module.

## Test plan
All scenarios use `REFRESH_DIV`=8 and `GAP_CYCLES`=2.
- Reset, `en`=0 for 20 cycles -> `an_n`=F, `seg_n`=7F, `dp_n`=1, no `frame_done`.
- `load` `value`=16'h1234, `dp`=4'b0010, `en`=1 -> after the boundary, a frame shows `seg_n` ~30/~6D/~79/~33 for digits 3..0, each for 6 cycles then 2 dark; `dp_n`=0 only on digit 1.
- `load` 16'hABCD mid-frame -> current frame unchanged; next frame shows A/b/C/d; `frame_done` period 32 cycles.
- `load` on the exact boundary cycle with 16'hFFFF -> the following frame shows all F, not the old pending value.
- `rst` pulsed during digit 2 SHOW -> outputs reach reset values with no clock edge; resume at digit 0.
- With `LEADING_ZERO_BLANK_EN`, `value`=16'h0050 -> digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0.
